// File: rtl/tdm_demux4_pkg.sv
// Shared types and sizing for the four-channel TDM demultiplexer.
package tdm_demux4_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int SLOT_W = 2;
  localparam int NUM_CH = 4;

endpackage

// File: rtl/tdm_demux4_dec_2_4.sv
// Gated 2-to-4 one-hot decoder: one output high for the selected slot when en is set.
module dec_2_4
  import tdm_demux4_pkg::*;
(
  input  logic              en,
  input  logic [SLOT_W-1:0] sel,
  output logic [NUM_CH-1:0] onehot
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_dec
    assign onehot[gi] = en && (sel == SLOT_W'(gi));
  end

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer: hunts for a sync-marked slot-0 word, then routes
// each valid word to its slot's channel register, realigning on an early sync.
module tdm_demux4
  import tdm_demux4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] ch0,
  output logic [WIDTH-1:0] ch1,
  output logic [WIDTH-1:0] ch2,
  output logic [WIDTH-1:0] ch3,
  output logic [3:0]       ch_valid,
  output logic [1:0]       slot,
  output logic             frame_done,
  output logic             sync_err
);

  state_t              state_reg, state_next;
  logic [SLOT_W-1:0]   slot_reg, slot_next, wr_slot;
  logic                wr_en, sync_err_next;
  logic [NUM_CH-1:0]   wr_onehot, ch_valid_reg;
  logic                frame_done_reg, sync_err_reg;
  logic [WIDTH-1:0]    ch_reg [NUM_CH];

  // A sync word always lands in slot 0, whether it starts or realigns the frame.
  always_comb begin
    wr_en         = 1'b0;
    wr_slot       = slot_reg;
    sync_err_next = 1'b0;
    state_next    = state_reg;
    slot_next     = slot_reg;
    case (state_reg)
      HUNT: begin
        if (din_valid && sync) begin
          wr_en      = 1'b1;
          wr_slot    = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        if (din_valid) begin
          wr_en = 1'b1;
          if (sync) begin
            wr_slot       = '0;
            sync_err_next = (slot_reg != '0);
          end
        end
      end
      default: state_next = HUNT;
    endcase
    if (wr_en) slot_next = wr_slot + 1'b1;
  end

  dec_2_4 u_dec (
    .en     (wr_en),
    .sel    (wr_slot),
    .onehot (wr_onehot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= HUNT;
      slot_reg       <= '0;
      ch_valid_reg   <= '0;
      frame_done_reg <= 1'b0;
      sync_err_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      slot_reg       <= slot_next;
      ch_valid_reg   <= wr_onehot;
      frame_done_reg <= wr_onehot[NUM_CH-1];
      sync_err_reg   <= sync_err_next;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ch_reg[gi] <= '0;
      end else if (wr_onehot[gi]) begin
        ch_reg[gi] <= din;
      end
    end
  end

  assign ch0        = ch_reg[0];
  assign ch1        = ch_reg[1];
  assign ch2        = ch_reg[2];
  assign ch3        = ch_reg[3];
  assign ch_valid   = ch_valid_reg;
  assign slot       = slot_reg;
  assign frame_done = frame_done_reg;
  assign sync_err   = sync_err_reg;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 with a slot-level reference model checked every cycle.
module tb_tdm_demux4;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       sync;
  logic [7:0] ch0, ch1, ch2, ch3;
  logic [3:0] ch_valid;
  logic [1:0] slot;
  logic       frame_done;
  logic       sync_err;

  tdm_demux4 #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .sync       (sync),
    .ch0        (ch0),
    .ch1        (ch1),
    .ch2        (ch2),
    .ch3        (ch3),
    .ch_valid   (ch_valid),
    .slot       (slot),
    .frame_done (frame_done),
    .sync_err   (sync_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: framing flag, next slot number and last word per channel.
  bit         m_run;
  int         m_slot;
  logic [7:0] m_ch [4];
  logic [3:0] m_vld;
  bit         m_fd;
  bit         m_err;

  int cycle = 0;
  int fd_cycles[$];
  bit err_seen;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run  = 0;
    m_slot = 0;
    for (int i = 0; i < 4; i++) m_ch[i] = 8'h00;
    m_vld  = 4'b0000;
    m_fd   = 0;
    m_err  = 0;
  endtask

  task automatic model_update(input bit v, input bit s, input logic [7:0] d);
    m_vld = 4'b0000;
    m_fd  = 0;
    m_err = 0;
    if (rst_n && v) begin
      if (!m_run) begin
        if (s) begin
          m_ch[0] = d;
          m_vld   = 4'b0001;
          m_slot  = 1;
          m_run   = 1;
        end
      end else if (s && m_slot != 0) begin
        m_err   = 1;
        m_ch[0] = d;
        m_vld   = 4'b0001;
        m_slot  = 1;
      end else begin
        m_ch[m_slot] = d;
        m_vld        = 4'(1 << m_slot);
        m_fd         = (m_slot == 3);
        m_slot       = (m_slot + 1) % 4;
      end
    end
  endtask

  task automatic send(input bit v, input bit s, input logic [7:0] d);
    din_valid = v;
    sync      = s;
    din       = d;
    @(posedge clk);
    model_update(v, s, d);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    din_valid = 1'b0;
    sync      = 1'b0;
    din       = 8'h00;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    model_update(0, 0, 8'h00);
    #1;
  endtask

  always @(negedge clk) begin
    cycle++;
    check("ch0", ch0, m_ch[0]);
    check("ch1", ch1, m_ch[1]);
    check("ch2", ch2, m_ch[2]);
    check("ch3", ch3, m_ch[3]);
    check("ch_valid", ch_valid, m_vld);
    check("slot", slot, m_slot);
    check("frame_done", frame_done, m_fd);
    check("sync_err", sync_err, m_err);
    if (frame_done) fd_cycles.push_back(cycle);
    if (sync_err) err_seen = 1;
  end

  initial begin
    rst_n = 1'b1;
    din_valid = 1'b0;
    sync = 1'b0;
    din = 8'h00;
    model_reset();
    #1;
    do_reset();
    check("reset_ch0", ch0, 8'h00);
    check("reset_slot", slot, 0);
    check("reset_valid", ch_valid, 4'b0000);

    // Basic aligned frame
    send(1, 1, 8'hA1);
    check("f1_valid0", ch_valid, 4'b0001);
    check("f1_slot1", slot, 1);
    send(1, 0, 8'hB2);
    send(1, 0, 8'hC3);
    send(1, 0, 8'hD4);
    check("f1_valid3", ch_valid, 4'b1000);
    check("f1_done", frame_done, 1);
    send(0, 0, 8'h00);
    check("f1_ch0", ch0, 8'hA1);
    check("f1_ch1", ch1, 8'hB2);
    check("f1_ch2", ch2, 8'hC3);
    check("f1_ch3", ch3, 8'hD4);
    check("f1_slot_end", slot, 0);
    check("f1_done_gone", frame_done, 0);

    // Two back-to-back aligned frames
    fd_cycles.delete();
    err_seen = 0;
    for (int i = 0; i < 8; i++) send(1, (i % 4) == 0, 8'(8'h10 + i));
    send(0, 0, 8'h00);
    check("b2b_done_count", fd_cycles.size(), 2);
    if (fd_cycles.size() == 2) check("b2b_done_spacing", fd_cycles[1] - fd_cycles[0], 4);
    check("b2b_no_err", err_seen, 0);
    check("b2b_ch3", ch3, 8'h17);
    check("b2b_slot", slot, 0);

    // Words without sync after reset are dropped
    do_reset();
    send(1, 0, 8'h55);
    send(1, 0, 8'h66);
    check("hunt_ch0", ch0, 8'h00);
    check("hunt_ch1", ch1, 8'h00);
    check("hunt_slot", slot, 0);
    check("hunt_valid", ch_valid, 4'b0000);
    send(1, 1, 8'h77);
    check("hunt_lock_ch0", ch0, 8'h77);
    check("hunt_lock_slot", slot, 1);

    // Early sync realigns and flags an error
    do_reset();
    send(1, 1, 8'h01);
    send(1, 0, 8'h02);
    send(1, 0, 8'h03);
    send(1, 0, 8'h04);
    send(1, 1, 8'h11);
    send(1, 0, 8'h22);
    send(1, 1, 8'h33);
    check("realign_err", sync_err, 1);
    check("realign_ch0", ch0, 8'h33);
    check("realign_slot", slot, 1);
    check("realign_ch1", ch1, 8'h22);
    check("realign_ch2", ch2, 8'h03);
    check("realign_ch3", ch3, 8'h04);
    send(0, 0, 8'h00);
    check("realign_err_pulse", sync_err, 0);

    // Gaps with sync toggling while din_valid is low
    do_reset();
    err_seen = 0;
    send(1, 1, 8'hA1);
    send(0, 1, 8'hFF);
    send(1, 0, 8'hB2);
    send(0, 1, 8'hEE);
    send(0, 0, 8'hDD);
    send(1, 0, 8'hC3);
    send(0, 1, 8'hCC);
    send(1, 0, 8'hD4);
    check("gap_done", frame_done, 1);
    send(0, 1, 8'hBB);
    check("gap_ch0", ch0, 8'hA1);
    check("gap_ch1", ch1, 8'hB2);
    check("gap_ch2", ch2, 8'hC3);
    check("gap_ch3", ch3, 8'hD4);
    check("gap_slot", slot, 0);
    check("gap_no_err", err_seen, 0);

    // Asynchronous reset between edges mid-frame
    send(1, 1, 8'h01);
    send(1, 0, 8'h02);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("async_ch0", ch0, 8'h00);
    check("async_ch1", ch1, 8'h00);
    check("async_ch3", ch3, 8'h00);
    check("async_slot", slot, 0);
    check("async_valid", ch_valid, 4'b0000);
    send(1, 1, 8'h44);
    send(1, 0, 8'h45);
    check("inreset_ch0", ch0, 8'h00);
    #3 rst_n = 1'b1;
    send(1, 0, 8'h99);
    check("post_drop_ch0", ch0, 8'h00);
    check("post_drop_slot", slot, 0);
    send(1, 1, 8'h5A);
    check("post_lock_ch0", ch0, 8'h5A);
    check("post_lock_slot", slot, 1);
    send(0, 0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
